// File: rtl/mpr121_poller_pkg.sv
// mpr121_defs: shared states, register map and command encodings for the MPR121 poller
// Contents: poller_state_t sequencer states, MPR121 register constants,
// electrode count, and i2c_master command flag bundles {start, read, write, write_multiple, stop}.
package mpr121_defs;
  localparam int MPR121_ELECTRODES = 12;
  localparam logic [7:0] MPR121_REG_STATUS = 8'h00;
  localparam logic [7:0] MPR121_REG_ECR = 8'h5E;
  localparam logic [7:0] MPR121_REG_SOFTRESET = 8'h80;
  localparam logic [7:0] MPR121_SOFTRESET_VAL = 8'h63;
  typedef enum logic [3:0] {
    RST_CMD, RST_REG, RST_VAL, ECR_CMD, ECR_REG, ECR_VAL, WAIT,
    PTR_CMD, PTR_DATA, RD0_CMD, RD0_DATA, RD1_CMD, RD1_DATA, UPDATE, ERR_WAIT
  } poller_state_t;
  typedef struct packed {
    logic start;
    logic read;
    logic write;
    logic write_multiple;
    logic stop;
  } cmd_flags_t;
  localparam cmd_flags_t CMD_REG_WRITE = 5'b10011;
  localparam cmd_flags_t CMD_PTR_WRITE = 5'b10100;
  localparam cmd_flags_t CMD_READ_FIRST = 5'b11000;
  localparam cmd_flags_t CMD_READ_LAST = 5'b01001;
endpackage

// File: rtl/mpr121_poller_holdoff.sv
// touch_holdoff: one electrode's press hold-off counter and press qualifier
// Ports: clk, rst_n (async active-low), update (status update strobe),
// rise (electrode newly touched), press (rise accepted because hold-off expired).
// A counter at 1 during the update cycle reaches 0 on that edge, so it already counts as expired.
module touch_holdoff #(
  parameter int HOLDOFF_CYCLES = 2700000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic update,
  input  logic rise,
  output logic press
);
  localparam int W = $clog2(HOLDOFF_CYCLES + 1);
  logic [W-1:0] cnt;
  assign press = rise && cnt <= W'(1);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt <= '0;
    else if (update && press) cnt <= W'(HOLDOFF_CYCLES);
    else if (cnt != '0) cnt <= cnt - W'(1);
endmodule

// File: rtl/mpr121_poller.sv
// mpr121_poller: init and periodic touch-status polling of one MPR121 over an i2c_master
// Ports: clk, rst_n (async active-low), enable (permits polling);
// m_cmd_* command stream, m_data_* write stream, s_rx_* read stream, missed_ack to/from i2c_master;
// init_done, touch_state, touch_press (1-cycle), toggle, error_count (saturating) to the front panel.
// Build option: MPR121_DEBOUNCE_EN adds a per-electrode press hold-off of HOLDOFF_CYCLES.
module mpr121_poller
  import mpr121_defs::*;
#(
  parameter logic [6:0] I2C_ADDR = 7'h5A,
  parameter logic [7:0] ECR_VALUE = 8'h8C,
  parameter int POLL_CYCLES = 270000,
  parameter int HOLDOFF_CYCLES = 2700000
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         enable,
  output logic [6:0]                   m_cmd_address,
  output logic                         m_cmd_start,
  output logic                         m_cmd_read,
  output logic                         m_cmd_write,
  output logic                         m_cmd_write_multiple,
  output logic                         m_cmd_stop,
  output logic                         m_cmd_valid,
  input  logic                         m_cmd_ready,
  output logic [7:0]                   m_data_tdata,
  output logic                         m_data_tvalid,
  output logic                         m_data_tlast,
  input  logic                         m_data_tready,
  input  logic [7:0]                   s_rx_tdata,
  input  logic                         s_rx_tvalid,
  input  logic                         s_rx_tlast,
  output logic                         s_rx_tready,
  input  logic                         missed_ack,
  output logic                         init_done,
  output logic [MPR121_ELECTRODES-1:0] touch_state,
  output logic [MPR121_ELECTRODES-1:0] touch_press,
  output logic [MPR121_ELECTRODES-1:0] toggle,
  output logic [7:0]                   error_count
);
  localparam int CW = $clog2(POLL_CYCLES + 1);
  poller_state_t state, nxt;
  cmd_flags_t flags;
  logic [CW-1:0] cnt;
  logic [7:0] dbyte, rx_lo;
  logic [3:0] rx_hi;
  logic dlast, cmd_st, data_st, rx_st, upd;
  logic [MPR121_ELECTRODES-1:0] new_touch, rise, press;
  assign cmd_st = state inside {RST_CMD, ECR_CMD, PTR_CMD, RD0_CMD, RD1_CMD};
  assign data_st = state inside {RST_REG, RST_VAL, ECR_REG, ECR_VAL, PTR_DATA};
  assign rx_st = state inside {RD0_DATA, RD1_DATA};
  assign upd = state == UPDATE && !missed_ack;
  // OVCF and the unused high-byte bits are dropped here
  assign new_touch = {rx_hi, rx_lo};
  assign rise = new_touch & ~touch_state;
`ifdef MPR121_DEBOUNCE_EN
  for (genvar i = 0; i < MPR121_ELECTRODES; i++) begin : g_hold
    touch_holdoff #(.HOLDOFF_CYCLES(HOLDOFF_CYCLES)) u_hold (
      .clk(clk), .rst_n(rst_n), .update(upd), .rise(rise[i]), .press(press[i])
    );
  end
`else
  assign press = rise;
`endif
  always_comb begin
    nxt = state;
    flags = '0;
    dbyte = MPR121_REG_STATUS;
    dlast = 1'b0;
    case (state)
      RST_CMD:  begin nxt = RST_REG; flags = CMD_REG_WRITE; end
      RST_REG:  begin nxt = RST_VAL; dbyte = MPR121_REG_SOFTRESET; end
      RST_VAL:  begin nxt = ECR_CMD; dbyte = MPR121_SOFTRESET_VAL; dlast = 1'b1; end
      ECR_CMD:  begin nxt = ECR_REG; flags = CMD_REG_WRITE; end
      ECR_REG:  begin nxt = ECR_VAL; dbyte = MPR121_REG_ECR; end
      ECR_VAL:  begin nxt = WAIT; dbyte = ECR_VALUE; dlast = 1'b1; end
      PTR_CMD:  begin nxt = PTR_DATA; flags = CMD_PTR_WRITE; end
      PTR_DATA: nxt = RD0_CMD;
      RD0_CMD:  begin nxt = RD0_DATA; flags = CMD_READ_FIRST; end
      RD0_DATA: nxt = RD1_CMD;
      RD1_CMD:  begin nxt = RD1_DATA; flags = CMD_READ_LAST; end
      RD1_DATA: nxt = UPDATE;
      default:  nxt = state;
    endcase
  end
  // Valids rise one cycle after entering a state and fall the cycle after the handshake,
  // so payload is only loaded while its valid is low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= RST_CMD;
      cnt <= '0;
      m_cmd_address <= '0;
      {m_cmd_start, m_cmd_read, m_cmd_write, m_cmd_write_multiple, m_cmd_stop} <= '0;
      m_cmd_valid <= 1'b0;
      m_data_tdata <= '0;
      m_data_tvalid <= 1'b0;
      m_data_tlast <= 1'b0;
      s_rx_tready <= 1'b0;
      rx_lo <= '0;
      rx_hi <= '0;
      init_done <= 1'b0;
      touch_state <= '0;
      touch_press <= '0;
      toggle <= '0;
      error_count <= '0;
    end else begin
      touch_press <= '0;
      if (missed_ack && state != WAIT) begin
        m_cmd_valid <= 1'b0;
        m_data_tvalid <= 1'b0;
        s_rx_tready <= 1'b0;
        init_done <= 1'b0;
        error_count <= error_count + {7'd0, error_count != 8'hFF};
        cnt <= '0;
        state <= ERR_WAIT;
      end else if (cmd_st) begin
        if (m_cmd_valid && m_cmd_ready) begin
          m_cmd_valid <= 1'b0;
          state <= nxt;
        end else if (!m_cmd_valid) begin
          m_cmd_valid <= 1'b1;
          m_cmd_address <= I2C_ADDR;
          {m_cmd_start, m_cmd_read, m_cmd_write, m_cmd_write_multiple, m_cmd_stop} <= flags;
        end
      end else if (data_st) begin
        if (m_data_tvalid && m_data_tready) begin
          m_data_tvalid <= 1'b0;
          init_done <= init_done || state == ECR_VAL;
          state <= nxt;
        end else if (!m_data_tvalid) begin
          m_data_tvalid <= 1'b1;
          m_data_tdata <= dbyte;
          m_data_tlast <= dlast;
        end
      end else if (rx_st) begin
        if (s_rx_tvalid && s_rx_tready) begin
          s_rx_tready <= 1'b0;
          rx_lo <= state == RD0_DATA ? s_rx_tdata : rx_lo;
          rx_hi <= state == RD1_DATA ? s_rx_tdata[3:0] : rx_hi;
          state <= nxt;
        end else s_rx_tready <= 1'b1;
      end else if (upd) begin
        touch_state <= new_touch;
        touch_press <= press;
        toggle <= toggle ^ press;
        state <= WAIT;
      end else if (cnt != CW'(POLL_CYCLES - 1)) cnt <= cnt + CW'(1);
      else if (state == ERR_WAIT || enable) begin
        cnt <= '0;
        state <= state == ERR_WAIT ? RST_CMD : PTR_CMD;
      end
    end
  end
endmodule

// File: tb/tb_mpr121_poller.sv
// tb_mpr121_poller: randomized self-checking bench with an i2c_master stand-in and a timestamp touch model
module tb_mpr121_poller;
  localparam int POLL = 100;
  localparam int HOLD = 2000;
`ifdef MPR121_DEBOUNCE_EN
  localparam bit DEB = 1'b1;
`else
  localparam bit DEB = 1'b0;
`endif
  logic clk = 1'b0, rst_n = 1'b0, enable = 1'b0;
  logic [6:0] m_cmd_address;
  logic m_cmd_start, m_cmd_read, m_cmd_write, m_cmd_write_multiple, m_cmd_stop, m_cmd_valid;
  logic m_cmd_ready = 1'b1;
  logic [7:0] m_data_tdata;
  logic m_data_tvalid, m_data_tlast;
  logic m_data_tready = 1'b1;
  logic [7:0] s_rx_tdata = 8'h00;
  logic s_rx_tvalid = 1'b0, s_rx_tlast = 1'b0, s_rx_tready;
  logic missed_ack = 1'b0, init_done;
  logic [11:0] touch_state, touch_press, toggle;
  logic [7:0] error_count;
  int checks = 0, errors = 0;
  always #5 clk = ~clk;
  mpr121_poller #(.POLL_CYCLES(POLL), .HOLDOFF_CYCLES(HOLD)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable),
    .m_cmd_address(m_cmd_address), .m_cmd_start(m_cmd_start), .m_cmd_read(m_cmd_read),
    .m_cmd_write(m_cmd_write), .m_cmd_write_multiple(m_cmd_write_multiple), .m_cmd_stop(m_cmd_stop),
    .m_cmd_valid(m_cmd_valid), .m_cmd_ready(m_cmd_ready),
    .m_data_tdata(m_data_tdata), .m_data_tvalid(m_data_tvalid), .m_data_tlast(m_data_tlast),
    .m_data_tready(m_data_tready),
    .s_rx_tdata(s_rx_tdata), .s_rx_tvalid(s_rx_tvalid), .s_rx_tlast(s_rx_tlast), .s_rx_tready(s_rx_tready),
    .missed_ack(missed_ack), .init_done(init_done), .touch_state(touch_state),
    .touch_press(touch_press), .toggle(toggle), .error_count(error_count)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, want);
    end
  endtask
  function automatic logic [15:0] cev(input logic [4:0] f);
    return {4'h1, 7'h5A, f};
  endfunction
  function automatic logic [15:0] dev(input logic [7:0] b, input logic l);
    return {4'h2, 3'b000, l, b};
  endfunction
  logic [15:0] ev[$];
  int ev_t[$];
  logic [7:0] rx_q[$];
  int cyc = 0, upd_cnt = 0, chk_at = 0, last_upd = 0;
  bit rx_pend, hi_next, chk_arm, upd_valid;
  logic [7:0] lo_b, b;
  logic [11:0] m_state, m_toggle, m_press, nw;
  longint last_p[12];
  // i2c_master stand-in plus reference model: a press is accepted when an electrode goes
  // from untouched to touched and (with hold-off) its last accepted press is >= HOLD cycles old
  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      if (!rst_n) begin
        ev.delete(); ev_t.delete(); rx_q.delete();
        rx_pend = 0; hi_next = 0; chk_arm = 0; upd_valid = 0;
        m_state = '0; m_toggle = '0; m_press = '0;
        for (int i = 0; i < 12; i++) last_p[i] = -1000000;
        s_rx_tvalid = 0; s_rx_tdata = 0; s_rx_tlast = 0;
        continue;
      end
      if (rx_pend) begin
        b = rx_q.pop_front();
        if (!hi_next) lo_b = b;
        else begin
          nw = {b[3:0], lo_b};
          m_press = '0;
          for (int i = 0; i < 12; i++)
            if (nw[i] && !m_state[i] && (!DEB || longint'(cyc + 1) - last_p[i] >= HOLD)) begin
              m_press[i] = 1'b1;
              last_p[i] = cyc + 1;
            end
          m_toggle ^= m_press;
          m_state = nw;
          chk_at = cyc + 1;
          chk_arm = 1;
        end
        hi_next = !hi_next;
      end
      if (chk_arm && cyc == chk_at + 1) begin
        check("press_width", touch_press, 0);
        chk_arm = 0;
      end
      if (chk_arm && cyc == chk_at) begin
        check("touch_state", touch_state, m_state);
        check("touch_press", touch_press, m_press);
        check("toggle", toggle, m_toggle);
        last_upd = cyc;
        upd_valid = 1;
        upd_cnt++;
      end
      if (m_cmd_valid && m_cmd_ready) begin
        ev.push_back({4'h1, m_cmd_address, m_cmd_start, m_cmd_read, m_cmd_write, m_cmd_write_multiple, m_cmd_stop});
        ev_t.push_back(cyc);
        if (upd_valid && {m_cmd_start, m_cmd_read, m_cmd_write, m_cmd_write_multiple, m_cmd_stop} == 5'b10100)
          check("poll_gap", 32'((cyc - last_upd) >= POLL), 1);
      end
      if (m_data_tvalid && m_data_tready) begin
        ev.push_back(dev(m_data_tdata, m_data_tlast));
        ev_t.push_back(cyc);
      end
      s_rx_tvalid = rx_q.size() > 0;
      s_rx_tdata = rx_q.size() > 0 ? rx_q[0] : 8'h00;
      s_rx_tlast = hi_next;
      rx_pend = s_rx_tvalid && s_rx_tready;
    end
  end
  task automatic wait_ev(input int n);
    int t = 0;
    while (ev.size() < n && t < 1000) begin
      @(posedge clk); #1;
      t++;
    end
    if (ev.size() < n) check("ev_timeout", ev.size(), n);
  endtask
  task automatic pop_ev(input string tag, input logic [15:0] want);
    logic [15:0] got = ev.size() > 0 ? ev.pop_front() : 16'hFFFF;
    if (ev_t.size() > 0) void'(ev_t.pop_front());
    check(tag, got, want);
  endtask
  task automatic expect_init(input int min_cyc);
    logic [15:0] want[6];
    want = '{cev(5'b10011), dev(8'h80, 0), dev(8'h63, 1), cev(5'b10011), dev(8'h5E, 0), dev(8'h8C, 1)};
    wait_ev(6);
    check("init_gap", 32'(ev_t.size() > 0 && ev_t[0] >= min_cyc), 1);
    for (int i = 0; i < 6; i++) pop_ev($sformatf("init%0d", i), want[i]);
    repeat (3) @(posedge clk);
    #1 check("init_done", init_done, 1);
  endtask
  task automatic do_poll(input logic [7:0] lo, input logic [7:0] hi);
    int u = upd_cnt, t = 0;
    @(posedge clk); #1;
    rx_q.push_back(lo);
    rx_q.push_back(hi);
    while (upd_cnt == u && t < 4 * POLL + 500) begin
      @(posedge clk); #1;
      t++;
    end
    if (upd_cnt == u) check("upd_timeout", 0, 1);
    pop_ev("ptr_cmd", cev(5'b10100));
    pop_ev("ptr_data", dev(8'h00, 0));
    pop_ev("rd0_cmd", cev(5'b11000));
    pop_ev("rd1_cmd", cev(5'b01001));
  endtask
  initial begin
    logic [11:0] p;
    bit stable;
    int t, miss;
    repeat (3) @(posedge clk);
    #1;
    check("rst_state", touch_state, 0);
    check("rst_toggle", toggle, 0);
    check("rst_press", touch_press, 0);
    check("rst_flags", {init_done, m_cmd_valid, m_data_tvalid, s_rx_tready}, 0);
    check("rst_errs", error_count, 0);
    rst_n = 1;
    expect_init(0);
    enable = 1;
    do_poll(8'h08, 8'h00);
    check("first_state", touch_state, 12'h008);
    check("first_t3", toggle[3], 1);
    do_poll(8'h08, 8'h00);
    do_poll(8'h00, 8'h82);
    check("ovcf_state", touch_state, 12'h200);
    do_poll(8'h00, 8'h00);
    do_poll(8'h08, 8'h00);
    check("hold_t3", toggle[3], DEB);
    do_poll(8'h00, 8'h00);
    repeat (HOLD + 50) @(posedge clk);
    do_poll(8'h08, 8'h00);
    check("after_t3", toggle[3], !DEB);
    for (int i = 0; i < 20; i++) begin
      case ($urandom_range(0, 3))
        0: do_poll(8'($urandom), 8'($urandom));
        1: do_poll(8'h00, 8'($urandom) & 8'hF0);
        2: do_poll(8'h08, 8'($urandom_range(0, 3)));
        default: do_poll(8'($urandom) & 8'h1F, 8'($urandom));
      endcase
    end
    enable = 0;
    repeat (3 * POLL) @(posedge clk);
    #1 check("idle_ev", ev.size(), 0);
    enable = 1;
    m_cmd_ready = 0;
    t = 0;
    while (!m_cmd_valid && t < 4 * POLL) begin
      @(negedge clk);
      t++;
    end
    check("bp_cmd", {m_cmd_valid, m_cmd_address, m_cmd_start, m_cmd_read, m_cmd_write, m_cmd_write_multiple, m_cmd_stop},
          {1'b1, 7'h5A, 5'b10100});
    p = {m_cmd_address, m_cmd_start, m_cmd_read, m_cmd_write, m_cmd_write_multiple, m_cmd_stop};
    stable = 1;
    repeat (50) begin
      @(negedge clk);
      stable &= m_cmd_valid && p == {m_cmd_address, m_cmd_start, m_cmd_read, m_cmd_write, m_cmd_write_multiple, m_cmd_stop};
    end
    check("bp_stable", stable, 1);
    @(posedge clk); #1 missed_ack = 1;
    @(posedge clk); #1 missed_ack = 0;
    miss = cyc;
    check("err_count", error_count, 1);
    check("err_init", init_done, 0);
    check("err_valid", m_cmd_valid, 0);
    m_cmd_ready = 1;
    expect_init(miss + POLL);
    do_poll(8'h08, 8'h00);
    @(posedge clk); #1;
    rx_q.push_back(8'h01);
    t = 0;
    while (!(ev.size() >= 4 && s_rx_tready) && t < 1000) begin
      @(posedge clk); #1;
      t++;
    end
    check("rd1_reached", s_rx_tready, 1);
    #2 rst_n = 0;
    #1;
    check("arst_state", touch_state, 0);
    check("arst_toggle", toggle, 0);
    check("arst_errs", error_count, 0);
    check("arst_flags", {init_done, s_rx_tready, m_cmd_valid, touch_press}, 0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1;
    expect_init(0);
    do_poll(8'h08, 8'h00);
    check("post_rst_t3", toggle[3], 1);
    repeat (5) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/mpr121_poller.md
# mpr121_poller

Sequencer that owns the `i2c_master` command/data streams for one MPR121 capacitive touch controller. After reset it:
- soft-resets the chip;
- enables the electrodes via the ECR register;
- then periodically reads the two touch-status bytes.

It turns the result into per-electrode touch state, press pulses and latched toggle flags. These feed the LED/display front panel logic.

## Interface
- `I2C_ADDR`, 7'h5A: MPR121 7-bit slave address
- `ECR_VALUE`, 8'h8C: value written to ECR (0x5E); 0x80 baseline tracking + 12 electrodes
- `POLL_CYCLES`, 270000: clk cycles from end of one status read to start of the next (10 ms @ 27 MHz)
- `HOLDOFF_CYCLES`, 2700000: per-electrode minimum cycles between accepted presses (100 ms @ 27 MHz)
- `clk` input 1: system clock
- `rst_n` input 1: asynchronous, active-low reset
- `enable` input 1: permits polling; init runs regardless
- `m_cmd_address` output 7: to `i2c_master` `s_axis_cmd_address`
- `m_cmd_start`, `m_cmd_read`, `m_cmd_write`, `m_cmd_write_multiple`, `m_cmd_stop` output 1 each: command flags
- `m_cmd_valid` output 1 / `m_cmd_ready` input 1: command handshake
- `m_data_tdata` output 8, `m_data_tvalid` output 1, `m_data_tlast` output 1 / `m_data_tready` input 1: write data stream
- `s_rx_tdata` input 8, `s_rx_tvalid` input 1, `s_rx_tlast` input 1 / `s_rx_tready` output 1: read data stream
- `missed_ack` input 1: from `i2c_master`
- `init_done` output 1: high once ECR write accepted, low after error or reset
- `touch_state` output 12: last status read, 1 = touched
- `touch_press` output 12: one-cycle pulse per accepted press
- `toggle` output 12: flips on each accepted press
- `error_count` output 8: saturating count of missed-ACK aborts

## Operation
- **Reset values:** all outputs 0, state `RST_CMD`, poll and hold-off counters 0.
- **Soft reset:**
  - `RST_CMD`: command start + write_multiple + stop to `I2C_ADDR`.
  - `RST_REG`: data 0x80.
  - `RST_VAL`: data 0x63, `tlast`=1.
- **ECR write:**
  - `ECR_CMD`, `ECR_REG` (0x5E), `ECR_VAL` (`ECR_VALUE`, `tlast`).
  - After `ECR_VAL` is accepted: `init_done`←1, go to `WAIT`.
- **`WAIT`:** count `POLL_CYCLES`. If `enable`=1 at expiry, go to `PTR_CMD`; otherwise stay in `WAIT` with the counter held at expiry.
- **Status read:**
  - `PTR_CMD`: start + write, no stop.
  - `PTR_DATA`: data 0x00, `tlast`=0.
  - `RD0_CMD`: start + read, no stop. `RD0_DATA`: capture low byte.
  - `RD1_CMD`: read + stop. `RD1_DATA`: capture high byte.
  - `UPDATE`, then back to `WAIT`.
- **`UPDATE` mapping:**
  - `new[7:0]` = low byte, `new[11:8]` = high byte[3:0]; high byte[7] (OVCF) is ignored.
  - Press on electrode i = `new[i] & ~touch_state[i]` and hold-off for i expired.
  - `touch_state` ← `new`.
- **Missed ACK:** `missed_ack` high in any state other than `WAIT` causes:
  - drop all valids;
  - `init_done`←0;
  - `error_count`++ (saturates at 255);
  - go to `ERR_WAIT` for `POLL_CYCLES`, then `RST_CMD`.

## Timing
- **Command/data valid:** registered, asserted the cycle after state entry. Payload is held stable while valid=1. The state advances on the cycle valid & ready is sampled, and valid drops the following cycle. Valid never drops before ready.
- **`s_rx_tready`:** asserted only in `RD0_DATA`/`RD1_DATA`. A byte is taken on `tvalid & tready`, and tready drops the next cycle.
- **`touch_press`:** high exactly 1 cycle, in the cycle after `UPDATE`. `toggle` and `touch_state` update in that same cycle.
- **Poll period:** `POLL_CYCLES` + I2C transaction time. There is no overlap of transactions.
- **Hold-off counters:** load `HOLDOFF_CYCLES` on an accepted press and decrement each clk to 0. A counter reaching 0 in the same cycle as `UPDATE` counts as expired.
- **`enable` falling mid-read:** the transaction completes and `UPDATE` occurs; the block then idles in `WAIT`.
- **`rst_n` low mid-transaction:** immediate return to reset values. `i2c_master` is reset by the same source and re-initialisation restarts from `RST_CMD`.

## Configuration
- `MPR121_DEBOUNCE_EN` defined: per-electrode hold-off as above.
- Not defined: hold-off counters are not built and every rising edge of `touch_state` is a press. `HOLDOFF_CYCLES` is ignored.

## Structure
- Package `mpr121_defs`:
  - state enum `poller_state_t`;
  - register constants `MPR121_REG_STATUS`=8'h00, `MPR121_REG_ECR`=8'h5E, `MPR121_REG_SOFTRESET`=8'h80, `MPR121_SOFTRESET_VAL`=8'h63;
  - `MPR121_ELECTRODES`=12.
- Sub-module `touch_holdoff`: one electrode's hold-off counter plus press qualify, instantiated 12 times in a generate loop. It exists only under `MPR121_DEBOUNCE_EN`.

## Test plan
- **Init sequence:** after reset, with an `i2c_master` model always ready, the bench sees:
  - cmd {addr 0x5A, start, write_multiple, stop};
  - data 0x80, then 0x63 with last;
  - the same command again, then data 0x5E, then 0x8C with last;
  - `init_done`=1.
- **Single touch:** `enable`=1, status bytes 0x08/0x00 → `touch_state`=12'h008, `touch_press`[3] pulses one cycle, `toggle`[3]=1.
- **Held touch and 0x00 high byte:** next poll returns 0x08/0x00 again → no press. A following 0x00/0x02 poll gives `touch_state`=12'h200 and `touch_press`[9] pulses.
- **Hold-off (`MPR121_DEBOUNCE_EN`):**
  - release and re-touch of electrode 3 within 2.7M cycles → no second press, `toggle`[3] stays 1;
  - after hold-off, release and re-touch → `toggle`[3]=0.
- **Missed ACK:** `missed_ack` pulsed during `PTR_CMD` → `error_count`=1, `init_done`=0, full init repeats after `POLL_CYCLES`.
- **Backpressure and reset:** `m_cmd_ready` held low for 50 cycles → valid and payload stay stable. `rst_n` asserted mid-`RD1_DATA` → all outputs return to 0 asynchronously.
